// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with master 0 as default owner, grant hold
// for fixed-length bursts and locked sequences, registered HGRANT/HMASTER/HMASTLOCK.
module ahb_arbiter #(
  parameter int NUM_MASTERS = 3
) (
  input  logic                   HMASTCLOCK,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [1:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [NUM_MASTERS-1:0] GRANT_M0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCKED} state_t;

  state_t                 state_reg;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic [1:0]             master_reg;
  logic                   mastlock_reg;
  logic [3:0]             cnt_reg;
  logic                   unlock_seen_reg;

  logic [1:0]             gidx;
  logic [2:0]             cand;
  logic [NUM_MASTERS-1:0] rr_onehot;
  logic [NUM_MASTERS-1:0] sel_onehot;
  logic                   owner_lock;
  logic                   owner_hlock;
  logic                   sel_lock;
  logic                   burst_start;
  logic [3:0]             burst_len;
  logic                   do_arb;

  assign HGRANT    = grant_reg;
  assign HMASTER   = master_reg;
  assign HMASTLOCK = mastlock_reg;

  always_comb begin
    gidx = 2'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_reg[i]) gidx = gidx | 2'(i);
    end
  end

  // Descending offsets so the nearest requester after the owner wins; no requester leaves master 0.
  always_comb begin
    rr_onehot = GRANT_M0;
    cand      = 3'd0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = {1'b0, gidx} + 3'(k);
      if (cand >= 3'(NUM_MASTERS)) cand = cand - 3'(NUM_MASTERS);
      if (HBUSREQ[cand[1:0]]) rr_onehot = GRANT_M0 << cand[1:0];
    end
  end

  // An owner that is requesting with HLOCK keeps the bus and becomes the locked master.
  assign owner_hlock = |(HLOCK & grant_reg);
  assign owner_lock  = |(HLOCK & HBUSREQ & grant_reg);
  assign sel_onehot  = owner_lock ? grant_reg : rr_onehot;
  assign sel_lock    = |(HLOCK & sel_onehot);

  assign burst_start = (state_reg == ST_ARB) && (HTRANS == TR_NONSEQ) &&
                       (HBURST[2:1] != 2'b00) && !owner_lock;

  always_comb begin
    case (HBURST[2:1])
      2'b01:   burst_len = 4'd3;
      2'b10:   burst_len = 4'd7;
      default: burst_len = 4'd15;
    endcase
  end

  always_comb begin
    do_arb = 1'b0;
    if (HREADY) begin
      case (state_reg)
        ST_ARB:    do_arb = !burst_start;
        ST_BURST:  do_arb = ((HTRANS == TR_SEQ) && (cnt_reg <= 4'd1)) ||
                            (HTRANS == TR_IDLE) || (HTRANS == TR_NONSEQ);
        ST_LOCKED: do_arb = unlock_seen_reg;
        default:   do_arb = 1'b1;
      endcase
    end
  end

  always_ff @(posedge HMASTCLOCK) begin
    if (reset) begin
      state_reg       <= ST_ARB;
      grant_reg       <= GRANT_M0;
      master_reg      <= 2'd0;
      mastlock_reg    <= 1'b0;
      cnt_reg         <= 4'd0;
      unlock_seen_reg <= 1'b0;
    end else if (HREADY) begin
      master_reg   <= gidx;
      mastlock_reg <= owner_hlock;
      if (do_arb) begin
        grant_reg       <= sel_onehot;
        state_reg       <= sel_lock ? ST_LOCKED : ST_ARB;
        cnt_reg         <= 4'd0;
        unlock_seen_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_ARB: begin
            state_reg <= ST_BURST;
            cnt_reg   <= burst_len;
          end
          ST_BURST: begin
            if (HTRANS == TR_SEQ) cnt_reg <= cnt_reg - 4'd1;
          end
          ST_LOCKED: begin
            if (!owner_hlock) unlock_seen_reg <= 1'b1;
          end
          default: state_reg <= ST_ARB;
        endcase
      end
    end
  end

  logic unused_busy;
  assign unused_busy = (TR_BUSY == 2'b01);

endmodule
